// File: rtl/chip_pack_if.sv
// rtl/chip_pack_if.sv - chip sample stream in, framed byte stream out
interface chip_pack_if;
  logic [15:0] chip_d;
  logic        chip_vld;
  logic [6:0]  chip_sel;
  logic [19:0] chip_len;
  logic        chip_rdy;
  logic [7:0]  pk_data;
  logic        pk_vld;
  logic        pk_ack;

  modport master (
    output chip_d, chip_vld, chip_sel, chip_len, pk_ack,
    input  chip_rdy, pk_data, pk_vld
  );

  modport slave (
    input  chip_d, chip_vld, chip_sel, chip_len, pk_ack,
    output chip_rdy, pk_data, pk_vld
  );
endinterface

// File: rtl/chip_pack.sv
// rtl/chip_pack.sv - chip packetizer: sync/header/data/checksum framing with word FIFO
module chip_pack #(
  parameter int          FIFO_AW = 4,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A,
  parameter logic [15:0] FILL    = 16'h8000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  chip_pack_if.slave  io,
  output logic        busy,
  output logic [7:0]  ovf_cnt,
  output logic [15:0] frame_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, DATA_H, DATA_L, CSUM} state_t;
  state_t state, state_n;

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  logic [6:0]  sel_q;
  logic [19:0] len_q, in_cnt, out_cnt;
  logic [7:0]  csum, lo_q, data_q;
  logic [2:0]  idx;
  logic        csum_sent, vld_q, rdy_q;

  logic        slot, load, add_csum, pop, push, drop, start, sample_ok;
  logic        fifo_full, fifo_empty;
  logic [7:0]  load_byte;
  logic [15:0] src_word;

  assign io.pk_data  = data_q;
  assign io.pk_vld   = vld_q;
  assign io.chip_rdy = rdy_q;

  // input-side acceptance and FIFO push/drop decisions (full judged on pre-cycle occupancy)
  always_comb begin
    slot       = !vld_q || io.pk_ack;
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    start      = (state == IDLE) && io.chip_vld && rdy_q && (io.chip_len != '0);
    sample_ok  = (state != IDLE) && io.chip_vld && (in_cnt < len_q);
    push       = (start || sample_ok) && !fifo_full;
    drop       = sample_ok && fifo_full;
  end

  // next state and what to load into the output register this cycle
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_byte = 8'h00;
    add_csum  = 1'b0;
    pop       = 1'b0;
    src_word  = FILL;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          load_byte = SYNC0;
          state_n   = HDR;
        end
      end
      HDR: begin
        if (slot) begin
          load     = 1'b1;
          add_csum = (idx >= 3'd2);
          case (idx)
            3'd1:    load_byte = SYNC1;
            3'd2:    load_byte = {1'b0, sel_q};
            3'd3:    load_byte = {4'h0, len_q[19:16]};
            3'd4:    load_byte = len_q[15:8];
            default: load_byte = len_q[7:0];
          endcase
          if (idx == 3'd5) state_n = DATA_H;
        end
      end
      DATA_H: begin
        // filler only once every sample of the chip has been seen and the FIFO is drained
        if (slot && (!fifo_empty || in_cnt == len_q)) begin
          pop       = !fifo_empty;
          src_word  = fifo_empty ? FILL : mem[rd_ptr];
          load      = 1'b1;
          load_byte = src_word[15:8];
          add_csum  = 1'b1;
          state_n   = DATA_L;
        end
      end
      DATA_L: begin
        if (slot) begin
          load      = 1'b1;
          load_byte = lo_q;
          add_csum  = 1'b1;
          state_n   = (out_cnt + 20'd1 == len_q) ? CSUM : DATA_H;
        end
      end
      CSUM: begin
        if (!csum_sent) begin
          load      = slot;
          load_byte = csum;
        end else if (io.pk_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= io.chip_d;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end
  end

  // output register, frame bookkeeping and status counters
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
      busy      <= 1'b0;
      ovf_cnt   <= 8'h00;
      frame_cnt <= 16'h0000;
      sel_q     <= '0;
      len_q     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      csum      <= 8'h00;
      lo_q      <= 8'h00;
      idx       <= 3'd0;
      csum_sent <= 1'b0;
    end else begin
      rdy_q <= (state_n == IDLE);
      busy  <= (state_n != IDLE);
      if (load) begin
        vld_q  <= 1'b1;
        data_q <= load_byte;
      end else if (io.pk_ack) begin
        vld_q <= 1'b0;
      end
      if (start) begin
        sel_q     <= io.chip_sel;
        len_q     <= io.chip_len;
        in_cnt    <= 20'd1;
        out_cnt   <= '0;
        csum      <= 8'h00;
        idx       <= 3'd1;
        csum_sent <= 1'b0;
      end else begin
        if (sample_ok)                 in_cnt    <= in_cnt + 20'd1;
        if (add_csum)                  csum      <= csum + load_byte;
        if (state == HDR && load)      idx       <= idx + 3'd1;
        if (state == DATA_H && load)   lo_q      <= src_word[7:0];
        if (state == DATA_L && load)   out_cnt   <= out_cnt + 20'd1;
        if (state == CSUM && load)     csum_sent <= 1'b1;
        if (drop && ovf_cnt != 8'hFF)  ovf_cnt   <= ovf_cnt + 8'd1;
        if (state == CSUM && csum_sent && io.pk_ack) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_chip_pack.sv
// tb/tb_chip_pack.sv - scoreboard bench for chip_pack framing, back-pressure and overflow
module tb_chip_pack;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [7:0]  ovf_cnt;
  logic [15:0] frame_cnt;

  chip_pack_if io ();

  chip_pack dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .io        (io),
    .busy      (busy),
    .ovf_cnt   (ovf_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_q[$];
  bit         ack_toggle = 1'b0;
  bit         hold = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    io.chip_vld = 1'b1;
    io.chip_d   = d;
    @(posedge clk_sys);
    #1;
    io.chip_vld = 1'b0;
  endtask

  task automatic exp_hdr(input logic [6:0] sel, input logic [19:0] len);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back({1'b0, sel});
    exp_q.push_back({4'h0, len[19:16]});
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
  endtask

  task automatic exp_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_frame(input logic [15:0] target, input int budget, output int cycles);
    cycles = 0;
    while (frame_cnt != target && cycles < budget) begin
      step(1);
      cycles++;
    end
    if (frame_cnt != target) check("frame_timeout", frame_cnt, target);
  endtask

  // alternating acknowledge for the back-pressure case
  initial forever begin
    @(posedge clk_sys);
    #1;
    if (ack_toggle) io.pk_ack = !io.pk_ack;
  end

  // monitor: stability of held bytes and scoreboard comparison of accepted bytes
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) check("held_byte", {io.pk_vld, io.pk_data}, {1'b1, hold_data});
      if (io.pk_vld && io.pk_ack) begin
        if (exp_q.size() == 0) check("unexpected_byte", io.pk_data, 9'h1FF);
        else check("byte", io.pk_data, exp_q.pop_front());
      end
      hold      = io.pk_vld && !io.pk_ack;
      hold_data = io.pk_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    io.chip_d   = '0;
    io.chip_vld = 1'b0;
    io.chip_sel = '0;
    io.chip_len = '0;
    io.pk_ack   = 1'b0;
    step(3);
    check("rst_pk_vld", io.pk_vld, 1'b0);
    check("rst_pk_data", io.pk_data, 8'h00);
    check("rst_chip_rdy", io.chip_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf_cnt, 8'h00);
    check("rst_frame", frame_cnt, 16'h0000);
    rst_n = 1'b1;
    step(1);
    check("rdy_after_rst", io.chip_rdy, 1'b1);

    // basic frame: A5 5A 05 00 00 02 01 02 FF FE 07
    io.pk_ack = 1'b1; io.chip_sel = 7'd5; io.chip_len = 20'd2;
    exp_hdr(7'd5, 20'd2); exp_word(16'h0102); exp_word(16'hFFFE); exp_q.push_back(8'h07);
    send(16'h0102);
    check("start_vld", io.pk_vld, 1'b1);
    check("start_sync0", io.pk_data, 8'hA5);
    check("start_rdy_low", io.chip_rdy, 1'b0);
    check("start_busy", busy, 1'b1);
    send(16'hFFFE);
    wait_frame(16'd1, 50, n);
    check("frame_len_cycles", n + 1, 11);
    check("basic_rdy", io.chip_rdy, 1'b1);
    check("basic_ovf", ovf_cnt, 8'h00);
    check("basic_frame", frame_cnt, 16'd1);
    check("basic_q_empty", exp_q.size(), 0);

    // back-pressure: A5 5A 03 00 00 01 12 34 4A
    io.chip_sel = 7'd3; io.chip_len = 20'd1;
    exp_hdr(7'd3, 20'd1); exp_word(16'h1234); exp_q.push_back(8'h4A);
    ack_toggle = 1'b1;
    send(16'h1234);
    wait_frame(16'd2, 60, n);
    ack_toggle = 1'b0; io.pk_ack = 1'b1;
    step(2);
    check("bp_q_empty", exp_q.size(), 0);

    // overflow: 16 words kept, 4 dropped and padded with 8000, csum A3
    io.pk_ack = 1'b0; io.chip_sel = 7'd7; io.chip_len = 20'd20;
    exp_hdr(7'd7, 20'd20);
    for (int i = 1; i <= 16; i++) exp_word(16'(i));
    for (int i = 0; i < 4; i++) exp_word(16'h8000);
    exp_q.push_back(8'hA3);
    for (int i = 1; i <= 20; i++) send(16'(i));
    check("ovf_count", ovf_cnt, 8'd4);
    io.pk_ack = 1'b1;
    wait_frame(16'd3, 100, n);
    check("ovf_q_empty", exp_q.size(), 0);

    // starvation: samples 10 cycles apart, output gaps, csum 4F
    io.chip_sel = 7'd1; io.chip_len = 20'd3;
    exp_hdr(7'd1, 20'd3); exp_word(16'h0A0B); exp_word(16'h0C0D); exp_word(16'h0E0F);
    exp_q.push_back(8'h4F);
    send(16'h0A0B);
    step(9);
    check("starve_gap1_vld", io.pk_vld, 1'b0);
    check("starve_gap1_busy", busy, 1'b1);
    send(16'h0C0D);
    step(9);
    check("starve_gap2_vld", io.pk_vld, 1'b0);
    send(16'h0E0F);
    wait_frame(16'd4, 50, n);
    check("starve_ovf", ovf_cnt, 8'd4);
    check("starve_q_empty", exp_q.size(), 0);

    // zero-length strobe in IDLE is ignored
    io.chip_len = 20'd0;
    send(16'h5555);
    check("len0_busy", busy, 1'b0);
    check("len0_vld", io.pk_vld, 1'b0);
    check("len0_rdy", io.chip_rdy, 1'b1);

    // extra strobe beyond len ignored, then back-to-back frame at the earliest slot
    io.chip_sel = 7'd2; io.chip_len = 20'd1;
    exp_hdr(7'd2, 20'd1); exp_word(16'h00FF); exp_q.push_back(8'h02);
    send(16'h00FF);
    send(16'h1111);
    wait_frame(16'd5, 50, n);
    io.chip_sel = 7'h7F; io.chip_len = 20'd1;
    exp_hdr(7'h7F, 20'd1); exp_word(16'hABCD); exp_q.push_back(8'hF8);
    send(16'hABCD);
    check("b2b_sync0", {io.pk_vld, io.pk_data}, {1'b1, 8'hA5});
    wait_frame(16'd6, 50, n);
    check("b2b_frames", frame_cnt, 16'd6);
    check("b2b_q_empty", exp_q.size(), 0);

    // reset while DATA_H waits for a word
    io.chip_sel = 7'd4; io.chip_len = 20'd3;
    exp_hdr(7'd4, 20'd3); exp_word(16'h1357);
    send(16'h1357);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin step(1); n++; end
    check("mid_q_drained", exp_q.size(), 0);
    step(1);
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_vld", io.pk_vld, 1'b0);
    check("mid_rst_rdy", io.chip_rdy, 1'b0);
    check("mid_rst_frame", frame_cnt, 16'd0);
    rst_n = 1'b1;
    step(1);
    check("mid_rdy_back", io.chip_rdy, 1'b1);
    io.chip_sel = 7'd5; io.chip_len = 20'd2;
    exp_hdr(7'd5, 20'd2); exp_word(16'h0102); exp_word(16'hFFFE); exp_q.push_back(8'h07);
    send(16'h0102);
    check("mid_new_sync0", {io.pk_vld, io.pk_data}, {1'b1, 8'hA5});
    send(16'hFFFE);
    wait_frame(16'd1, 50, n);
    check("mid_new_frame", frame_cnt, 16'd1);
    check("mid_new_ovf", ovf_cnt, 8'd0);
    check("mid_q_empty", exp_q.size(), 0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
